// File: rtl/sixbit_accum_ctrl.sv
// Accumulator controller around an external combinational 6-bit add/sub.
// Holds adder inputs stable for SETTLE_CYCLES, then captures sum and flags.
module sixbit_accum_ctrl #(
    parameter int WIDTH         = 6,
    parameter int SETTLE_CYCLES = 2,
    parameter bit SAT_EN        = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_sel,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_overflow,
    input  logic             add_c_out,
    output logic [WIDTH-1:0] acc,
    output logic             flag_ovf,
    output logic             flag_carry,
    output logic             flag_zero,
    output logic             done
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX_POS  = {WIDTH{1'b1}} >> 1;
    localparam logic [WIDTH-1:0] MIN_NEG  = ~MAX_POS;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] y_r, y_nxt;
    logic [1:0]       op_r, op_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic             flag_ovf_nxt, flag_carry_nxt, done_nxt;
    logic [WIDTH-1:0] capture_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            y_r        <= '0;
            op_r       <= '0;
            acc        <= '0;
            flag_ovf   <= 1'b0;
            flag_carry <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            y_r        <= y_nxt;
            op_r       <= op_nxt;
            acc        <= acc_nxt;
            flag_ovf   <= flag_ovf_nxt;
            flag_carry <= flag_carry_nxt;
            done       <= done_nxt;
        end
    end

    // Positive overflow wraps to a negative sum, so the sum's MSB picks the rail.
    always_comb begin
        capture_val = add_sum;
        if (SAT_EN && add_overflow)
            capture_val = add_sum[WIDTH-1] ? MAX_POS : MIN_NEG;
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        y_nxt          = y_r;
        op_nxt         = op_r;
        acc_nxt        = acc;
        flag_ovf_nxt   = flag_ovf;
        flag_carry_nxt = flag_carry;
        done_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_nxt = in_op;
                    y_nxt  = in_data;
                    case (in_op)
                        OP_ADD, OP_SUB: begin
                            state_nxt = SETTLE;
                            cnt_nxt   = CNT_INIT;
                        end
                        OP_LOAD: begin
                            acc_nxt  = in_data;
                            done_nxt = 1'b1;
                        end
                        OP_CLEAR: begin
                            acc_nxt        = '0;
                            flag_ovf_nxt   = 1'b0;
                            flag_carry_nxt = 1'b0;
                            done_nxt       = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            SETTLE: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    acc_nxt        = capture_val;
                    flag_carry_nxt = add_c_out;
                    flag_ovf_nxt   = flag_ovf | add_overflow;
                    done_nxt       = 1'b1;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign add_x     = acc;
    assign add_y     = y_r;
    assign add_sel   = op_r[0];
    assign flag_zero = (acc == '0);

endmodule

// File: tb/tb_sixbit_accum_ctrl.sv
// Bench for sixbit_accum_ctrl: one wrapping and one saturating instance driven in
// lockstep, each on its own behavioural 6-bit add/sub, against an integer model.
module tb_sixbit_accum_ctrl;

    localparam int W      = 6;
    localparam int SETTLE = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [1:0]   in_op;
    logic [W-1:0] in_data;

    logic         ready0, ready1;
    logic [W-1:0] ax0, ay0, sum0, acc0, ax1, ay1, sum1, acc1;
    logic         as0, ov0, co0, fo0, fc0, fz0, done0;
    logic         as1, ov1, co1, fo1, fc1, fz1, done1;

    int total = 0;
    int bad   = 0;

    int macc [2];
    bit movf [2];
    bit mcar [2];

    always #5 clk = ~clk;

    // Stand-in for the external ripple adder: {overflow, c_out, sum}.
    function automatic logic [W+1:0] adder(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sel);
        logic [W-1:0] yy;
        logic [W:0]   t;
        logic         ovf;
        yy  = sel ? ~y : y;
        t   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sel};
        ovf = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return {ovf, t[W], t[W-1:0]};
    endfunction

    assign {ov0, co0, sum0} = adder(ax0, ay0, as0);
    assign {ov1, co1, sum1} = adder(ax1, ay1, as1);

    sixbit_accum_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SETTLE), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready0),
        .in_op(in_op), .in_data(in_data), .add_x(ax0), .add_y(ay0), .add_sel(as0),
        .add_sum(sum0), .add_overflow(ov0), .add_c_out(co0), .acc(acc0),
        .flag_ovf(fo0), .flag_carry(fc0), .flag_zero(fz0), .done(done0)
    );

    sixbit_accum_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SETTLE), .SAT_EN(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready1),
        .in_op(in_op), .in_data(in_data), .add_x(ax1), .add_y(ay1), .add_sel(as1),
        .add_sum(sum1), .add_overflow(ov1), .add_c_out(co1), .acc(acc1),
        .flag_ovf(fo1), .flag_carry(fc1), .flag_zero(fz1), .done(done1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic on plain ints, rails chosen by the true result sign.
    task automatic modelOp(input logic [1:0] op, input int data);
        for (int k = 0; k < 2; k++) begin
            int a, sa, sy, sres, res;
            bit ov;
            a  = macc[k];
            sa = (a >= 32) ? a - 64 : a;
            sy = (data >= 32) ? data - 64 : data;
            case (op)
                2'b00, 2'b01: begin
                    sres = (op == 2'b00) ? sa + sy : sa - sy;
                    mcar[k] = (op == 2'b00) ? ((a + data) >= 64) : (a >= data);
                    ov  = (sres > 31) || (sres < -32);
                    res = (sres + 128) % 64;
                    if (k == 1 && ov) res = (sres > 31) ? 31 : 32;
                    macc[k] = res;
                    movf[k] = movf[k] | ov;
                end
                2'b10: macc[k] = data;
                default: begin
                    macc[k] = 0;
                    movf[k] = 1'b0;
                    mcar[k] = 1'b0;
                end
            endcase
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            macc[k] = 0;
            movf[k] = 1'b0;
            mcar[k] = 1'b0;
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_acc0"}, 32'(acc0), 32'(macc[0]));
        checkOutput({tag, "_acc1"}, 32'(acc1), 32'(macc[1]));
        checkOutput({tag, "_ovf0"}, 32'(fo0), 32'(movf[0]));
        checkOutput({tag, "_ovf1"}, 32'(fo1), 32'(movf[1]));
        checkOutput({tag, "_car0"}, 32'(fc0), 32'(mcar[0]));
        checkOutput({tag, "_car1"}, 32'(fc1), 32'(mcar[1]));
        checkOutput({tag, "_zero0"}, 32'(fz0), 32'(macc[0] == 0));
        checkOutput({tag, "_zero1"}, 32'(fz1), 32'(macc[1] == 0));
    endtask

    // Present a request, wait for acceptance, then measure the done latency.
    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] data);
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        n = 0;
        while (!ready0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) checkOutput("accept_timeout", 32'(ready0), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        modelOp(op, int'(data));
        n = 0;
        while (!done0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("done_latency", n, op[1] ? 0 : SETTLE);
        checkOutput("done_sat", 32'(done1), 32'd1);
        checkState("op");
        checkOutput("ready_after", 32'(ready0), 32'd1);
        @(posedge clk); #1;
        checkOutput("done_pulse", 32'(done0), 32'd0);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_data  = '0;
        modelReset();
        #1;
        checkOutput("rst_ready_low", 32'(ready0), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkState("rst");
        checkOutput("rst_done", 32'(done0), 32'd0);
        checkOutput("rst_ready", 32'(ready0), 32'd1);

        $display("[TB] basic add");
        applyStimulus(2'b10, 6'b000001);
        applyStimulus(2'b00, 6'b000000);
        checkOutput("t2_acc", 32'(acc0), 32'h01);
        checkOutput("t2_zero", 32'(fz0), 32'd0);

        $display("[TB] overflow");
        applyStimulus(2'b10, 6'b011111);
        applyStimulus(2'b00, 6'b000001);
        checkOutput("t3_acc_wrap", 32'(acc0), 32'h20);
        checkOutput("t3_ovf", 32'(fo0), 32'd1);
        checkOutput("t5_acc_sat", 32'(acc1), 32'h1F);
        applyStimulus(2'b00, 6'b000001);
        checkOutput("t3_acc_next", 32'(acc0), 32'h21);
        checkOutput("t3_ovf_sticky", 32'(fo0), 32'd1);
        applyStimulus(2'b11, 6'b000000);
        checkOutput("t3_clear_ovf", 32'(fo0), 32'd0);

        $display("[TB] subtract");
        applyStimulus(2'b10, 6'b000101);
        applyStimulus(2'b01, 6'b000101);
        checkOutput("t4_acc", 32'(acc0), 32'h00);
        checkOutput("t4_carry", 32'(fc0), 32'd1);
        applyStimulus(2'b01, 6'b000001);
        checkOutput("t4_borrow_acc", 32'(acc0), 32'h3F);
        checkOutput("t4_borrow", 32'(fc0), 32'd0);
        applyStimulus(2'b10, 6'b100000);
        applyStimulus(2'b01, 6'b000001);
        checkOutput("t5_sub_wrap", 32'(acc0), 32'h1F);
        checkOutput("t5_sub_sat", 32'(acc1), 32'h20);

        $display("[TB] request held during settle");
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_data  = 6'b000011;
        @(posedge clk); #1;
        in_op   = 2'b10;
        in_data = 6'b010101;
        checkOutput("t6_ready_busy", 32'(ready0), 32'd0);
        n = 0;
        while (!ready0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("t6_wait_cycles", n, SETTLE);
        modelOp(2'b00, 3);
        checkState("t6_add");
        @(posedge clk); #1;
        in_valid = 1'b0;
        modelOp(2'b10, 6'b010101);
        checkOutput("t6_load_acc", 32'(acc0), 32'h15);
        checkOutput("t6_load_done", 32'(done0), 32'd1);
        @(posedge clk); #1;

        $display("[TB] reset mid-settle");
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_data  = 6'b000111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        modelReset();
        #1;
        checkState("t6_rst");
        checkOutput("t6_rst_done", 32'(done0), 32'd0);
        checkOutput("t6_rst_ready", 32'(ready0), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("t6_no_done", 32'(done0 | done1), 32'd0);
        end
        checkOutput("t6_acc_after", 32'(acc0), 32'd0);
        applyStimulus(2'b10, 6'b001010);
        applyStimulus(2'b00, 6'b000101);

        $display("[TB] random ops");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), W'($urandom_range(0, 63)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
